// File: rtl/aie_arb_pkg.sv
// Shared types and helpers for the AIE policy arbiter and other shared-kernel arbiters.
package aie_arb_pkg;

    localparam int STAT_W = 16;
    localparam int RR_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACT = 2'd2,
        ST_DELIVER  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // First set request after 'last', wrapping modulo n (n <= RR_MAX).
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [3:0]        last,
                                         input logic [4:0]        n);
        rr_pick_t   res;
        logic [5:0] cand;
        res.found = 1'b0;
        res.idx   = 4'd0;
        for (int k = 1; k <= RR_MAX; k++) begin
            cand = {2'b00, last} + 6'(k);
            if (cand >= {1'b0, n}) begin
                cand = cand - {1'b0, n};
            end else begin
                cand = cand;
            end
            if ((k <= int'(n)) && !res.found && req[cand[3:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[3:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/aie_rr_arbiter.sv
// Combinational round-robin picker with optional strict priority for requester 0.
module aie_rr_arbiter
    import aie_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    input  logic               prio_en,
    output logic [IDX_W-1:0]   grant,
    output logic               any,
    output logic               prio_win
);

    logic [RR_MAX-1:0] req_pad_s;
    logic [3:0]        last_pad_s;
    rr_pick_t          pick_s;
    logic              unused_s;

    // Widen to the helper's fixed width and select the winner.
    always_comb begin
        req_pad_s                = '0;
        req_pad_s[NUM_REQ-1:0]   = req;
        last_pad_s               = '0;
        last_pad_s[IDX_W-1:0]    = last;
        pick_s                   = rr_pick(req_pad_s, last_pad_s, 5'(NUM_REQ));
        prio_win                 = prio_en & req[0];
        any                      = pick_s.found;
        if (prio_win) begin
            grant = '0;
        end else begin
            grant = pick_s.idx[IDX_W-1:0];
        end
    end

    assign unused_s = ^pick_s.idx;

endmodule

// File: rtl/aie_policy_arbiter.sv
// Shares one AIE policy inference path among NUM_REQ channels with a watchdog.
// Optional: define AIE_ARB_PRIORITY_EN to make requester 0 strict-high-priority.
module aie_policy_arbiter
    import aie_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int STATE_DIM      = 6,
    parameter int ACTION_DIM     = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_REQ-1:0]                      req_valid,
    input  logic [NUM_REQ*STATE_DIM*DATA_WIDTH-1:0] req_state_data,
    output logic [NUM_REQ-1:0]                      req_ready,
    output logic [NUM_REQ-1:0]                      rsp_valid,
    output logic [ACTION_DIM*DATA_WIDTH-1:0]        rsp_action_data,
    output logic                                    rsp_timeout,
    input  logic [NUM_REQ-1:0]                      rsp_ready,
    output logic                                    pol_state_valid,
    output logic [STATE_DIM*DATA_WIDTH-1:0]         pol_state_data,
    input  logic                                    pol_state_ready,
    input  logic                                    pol_action_valid,
    input  logic [ACTION_DIM*DATA_WIDTH-1:0]        pol_action_data,
    output logic                                    pol_action_ready,
    output logic [$clog2(NUM_REQ)-1:0]              grant_id,
    output logic [15:0]                             stat_timeouts,
    output logic [15:0]                             stat_grants
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam int SW    = STATE_DIM * DATA_WIDTH;
    localparam int AW    = ACTION_DIM * DATA_WIDTH;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
`ifdef AIE_ARB_PRIORITY_EN
    localparam logic PRIO_EN = 1'b1;
`else
    localparam logic PRIO_EN = 1'b0;
`endif

    arb_state_t         state_r, state_nx;
    logic [IDX_W-1:0]   last_r, grant_id_r, grant_s;
    logic               any_s, prio_win_s;
    logic [SW-1:0]      state_data_r;
    logic               pol_state_valid_r;
    logic [AW-1:0]      action_r;
    logic               rsp_timeout_r;
    logic [NUM_REQ-1:0] rsp_valid_r, req_ready_s;
    logic               drain_r;
    logic [WD_W-1:0]    wdog_r;
    logic [STAT_W-1:0]  stat_timeouts_r, stat_grants_r;
    logic               accept_s, state_hs_s, act_take_s, timeout_s, drain_clear_s, rsp_done_s;
    logic               pol_action_ready_s;

    aie_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req      (req_valid),
        .last     (last_r),
        .prio_en  (PRIO_EN),
        .grant    (grant_s),
        .any      (any_s),
        .prio_win (prio_win_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state decode and single-cycle event strobes.
    always_comb begin
        state_nx           = state_r;
        req_ready_s        = '0;
        accept_s           = 1'b0;
        state_hs_s         = 1'b0;
        act_take_s         = 1'b0;
        timeout_s          = 1'b0;
        rsp_done_s         = 1'b0;
        pol_action_ready_s = drain_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    req_ready_s = ONE_HOT0 << grant_s;
                    accept_s    = 1'b1;
                    state_nx    = ST_ISSUE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (pol_state_ready && pol_state_valid_r) begin
                    state_hs_s = 1'b1;
                    state_nx   = ST_WAIT_ACT;
                end else begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_WAIT_ACT: begin
                pol_action_ready_s = 1'b1;
                if (pol_action_valid && drain_r) begin
                    state_nx = ST_WAIT_ACT;
                end else if (pol_action_valid) begin
                    act_take_s = 1'b1;
                    state_nx   = ST_DELIVER;
                end else if (wdog_r == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_s = 1'b1;
                    state_nx  = ST_DELIVER;
                end else begin
                    state_nx = ST_WAIT_ACT;
                end
            end
            ST_DELIVER: begin
                if (rsp_valid_r[grant_id_r] && rsp_ready[grant_id_r]) begin
                    rsp_done_s = 1'b1;
                    state_nx   = ST_IDLE;
                end else begin
                    state_nx = ST_DELIVER;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        // A late action is swallowed whenever a timed-out inference is still owed one.
        drain_clear_s = drain_r & pol_action_valid & pol_action_ready_s;
    end

    // Datapath, watchdog, drain flag and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r            <= IDX_W'(NUM_REQ - 1);
            grant_id_r        <= '0;
            state_data_r      <= '0;
            pol_state_valid_r <= 1'b0;
            action_r          <= '0;
            rsp_timeout_r     <= 1'b0;
            rsp_valid_r       <= '0;
            drain_r           <= 1'b0;
            wdog_r            <= '0;
            stat_timeouts_r   <= '0;
            stat_grants_r     <= '0;
        end else begin
            if (accept_s) begin
                state_data_r      <= req_state_data[int'(grant_s)*SW +: SW];
                grant_id_r        <= grant_s;
                pol_state_valid_r <= 1'b1;
                stat_grants_r     <= stat_grants_r + STAT_W'(1);
                if (!prio_win_s) begin
                    last_r <= grant_s;
                end
            end else if (state_hs_s) begin
                pol_state_valid_r <= 1'b0;
            end

            if (state_hs_s) begin
                wdog_r <= '0;
            end else if (state_r == ST_WAIT_ACT) begin
                wdog_r <= wdog_r + WD_W'(1);
            end

            if (act_take_s) begin
                action_r      <= pol_action_data;
                rsp_timeout_r <= 1'b0;
            end else if (timeout_s) begin
                action_r      <= '0;
                rsp_timeout_r <= 1'b1;
                if (stat_timeouts_r != {STAT_W{1'b1}}) begin
                    stat_timeouts_r <= stat_timeouts_r + STAT_W'(1);
                end
            end

            if (timeout_s) begin
                drain_r <= 1'b1;
            end else if (drain_clear_s) begin
                drain_r <= 1'b0;
            end

            if (state_r == ST_DELIVER && rsp_valid_r == '0) begin
                rsp_valid_r <= ONE_HOT0 << grant_id_r;
            end else if (rsp_done_s) begin
                rsp_valid_r <= '0;
            end
        end
    end

    assign req_ready        = req_ready_s;
    assign rsp_valid        = rsp_valid_r;
    assign rsp_action_data  = action_r;
    assign rsp_timeout      = rsp_timeout_r;
    assign pol_state_valid  = pol_state_valid_r;
    assign pol_state_data   = state_data_r;
    assign pol_action_ready = pol_action_ready_s;
    assign grant_id         = grant_id_r;
    assign stat_timeouts    = stat_timeouts_r;
    assign stat_grants      = stat_grants_r;

endmodule

// File: tb/tb_aie_policy_arbiter.sv
// Self-checking bench for aie_policy_arbiter against a transaction-level reference model.
module tb_aie_policy_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int STATE_DIM      = 6;
    localparam int ACTION_DIM     = 2;
    localparam int DATA_WIDTH     = 32;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int SW             = STATE_DIM * DATA_WIDTH;
    localparam int AW             = ACTION_DIM * DATA_WIDTH;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*SW-1:0]          req_state_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [AW-1:0]                  rsp_action_data;
    logic                           rsp_timeout;
    logic [NUM_REQ-1:0]             rsp_ready;
    logic                           pol_state_valid;
    logic [SW-1:0]                  pol_state_data;
    logic                           pol_state_ready;
    logic                           pol_action_valid;
    logic [AW-1:0]                  pol_action_data;
    logic                           pol_action_ready;
    logic [$clog2(NUM_REQ)-1:0]     grant_id;
    logic [15:0]                    stat_timeouts;
    logic [15:0]                    stat_grants;

    int checks = 0;
    int errors = 0;
    int m_last, m_grants, m_timeouts;
    bit m_drain;
    logic [DATA_WIDTH-1:0] sw [NUM_REQ][STATE_DIM];

    aie_policy_arbiter #(
        .NUM_REQ(NUM_REQ), .STATE_DIM(STATE_DIM), .ACTION_DIM(ACTION_DIM),
        .DATA_WIDTH(DATA_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_state_data(req_state_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_action_data(rsp_action_data),
        .rsp_timeout(rsp_timeout), .rsp_ready(rsp_ready), .pol_state_valid(pol_state_valid),
        .pol_state_data(pol_state_data), .pol_state_ready(pol_state_ready),
        .pol_action_valid(pol_action_valid), .pol_action_data(pol_action_data),
        .pol_action_ready(pol_action_ready), .grant_id(grant_id),
        .stat_timeouts(stat_timeouts), .stat_grants(stat_grants)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last     = NUM_REQ - 1;
        m_grants   = 0;
        m_timeouts = 0;
        m_drain    = 1'b0;
    endtask

    function automatic int model_pick(input logic [NUM_REQ-1:0] v, output bit pw);
        pw = 1'b0;
`ifdef AIE_ARB_PRIORITY_EN
        if (v[0]) begin
            pw = 1'b1;
            return 0;
        end
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
        end
        return 0;
    endfunction

    task automatic load_states();
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < STATE_DIM; k++) begin
                sw[i][k] = $urandom();
                req_state_data[(i*STATE_DIM + k)*DATA_WIDTH +: DATA_WIDTH] = sw[i][k];
            end
        end
    endtask

    // One full transaction; lat < 0 means the policy never answers.
    task automatic run_txn(input logic [NUM_REQ-1:0] v, input int lat, input int hold, output int g);
        logic [SW-1:0]      exp_state;
        logic [AW-1:0]      exp_act;
        logic [NUM_REQ-1:0] exp_oh;
        logic               exp_to;
        bit                 pw;
        int                 n;
        load_states();
        req_valid = v;
        #1;
        g = model_pick(v, pw);
        exp_oh = NUM_REQ'(1) << g;
        n = 0;
        while (req_ready === '0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (req_ready !== exp_oh || n !== 0)
            begin errors++; $display("FAIL grant: req_ready %b after %0d cycles, expected %b at once", req_ready, n, exp_oh); end
        for (int k = 0; k < STATE_DIM; k++) exp_state[k*DATA_WIDTH +: DATA_WIDTH] = sw[g][k];
        exp_act = {sw[g][1], sw[g][0]};
        if (!pw) m_last = g;
        m_grants = (m_grants + 1) % 65536;
        tick();
        checks++;
        if (pol_state_valid !== 1'b1 || pol_state_data !== exp_state)
            begin errors++; $display("FAIL state_issue: valid %b data %h expected 1 %h", pol_state_valid, pol_state_data, exp_state); end
        checks++;
        if (grant_id !== 2'(g) || req_ready !== '0 || stat_grants !== 16'(m_grants))
            begin errors++; $display("FAIL grant_regs: grant_id %0d req_ready %b stat_grants %0d expected %0d 0 %0d", grant_id, req_ready, stat_grants, g, m_grants); end
        n = $urandom_range(0, 2);
        repeat (n) begin
            tick();
            checks++;
            if (pol_state_valid !== 1'b1 || pol_state_data !== exp_state)
                begin errors++; $display("FAIL state_hold: valid %b data %h expected 1 %h", pol_state_valid, pol_state_data, exp_state); end
        end
        pol_state_ready = 1'b1;
        tick();
        pol_state_ready = 1'b0;
        checks++;
        if (pol_state_valid !== 1'b0 || pol_action_ready !== 1'b1)
            begin errors++; $display("FAIL wait_entry: pol_state_valid %b pol_action_ready %b expected 0 1", pol_state_valid, pol_action_ready); end
        if (lat >= 0) begin
            repeat (lat) begin
                checks++;
                if (rsp_valid !== '0 || pol_action_ready !== 1'b1)
                    begin errors++; $display("FAIL wait_act: rsp_valid %b pol_action_ready %b expected 0 1", rsp_valid, pol_action_ready); end
                tick();
            end
            pol_action_valid = 1'b1;
            pol_action_data  = exp_act;
            tick();
            pol_action_valid = 1'b0;
            pol_action_data  = '0;
            checks++;
            if (rsp_valid !== '0)
                begin errors++; $display("FAIL rsp_early: rsp_valid %b expected 0", rsp_valid); end
            tick();
            exp_to = 1'b0;
        end else begin
            exp_act = '0;
            exp_to  = 1'b1;
            n = 0;
            while (rsp_valid === '0 && n < TIMEOUT_CYCLES + 10) begin
                tick();
                n++;
            end
            checks++;
            if (n !== TIMEOUT_CYCLES + 1)
                begin errors++; $display("FAIL timeout_latency: rsp after %0d cycles expected %0d", n, TIMEOUT_CYCLES + 1); end
            m_timeouts = (m_timeouts < 65535) ? m_timeouts + 1 : 65535;
            m_drain    = 1'b1;
        end
        checks++;
        if (rsp_valid !== exp_oh || rsp_action_data !== exp_act || rsp_timeout !== exp_to)
            begin errors++; $display("FAIL rsp: valid %b data %h timeout %b expected %b %h %b", rsp_valid, rsp_action_data, rsp_timeout, exp_oh, exp_act, exp_to); end
        checks++;
        if (stat_timeouts !== 16'(m_timeouts))
            begin errors++; $display("FAIL stat_timeouts: got %0d expected %0d", stat_timeouts, m_timeouts); end
        repeat (hold) begin
            rsp_ready = NUM_REQ'($urandom()) & ~exp_oh;
            tick();
            checks++;
            if (rsp_valid !== exp_oh || rsp_action_data !== exp_act || req_ready !== '0 ||
                pol_state_valid !== 1'b0 || pol_action_ready !== m_drain)
                begin errors++; $display("FAIL rsp_hold: valid %b data %h req_ready %b psv %b par %b expected %b %h 0 0 %b",
                    rsp_valid, rsp_action_data, req_ready, pol_state_valid, pol_action_ready, exp_oh, exp_act, m_drain); end
        end
        rsp_ready = exp_oh;
        tick();
        rsp_ready = '0;
        req_valid = '0;
        checks++;
        if (rsp_valid !== '0)
            begin errors++; $display("FAIL rsp_release: rsp_valid %b expected 0", rsp_valid); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_state_data = '0; rsp_ready = '0;
        pol_state_ready = 1'b0; pol_action_valid = 1'b0; pol_action_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_action_data, rsp_timeout, pol_state_valid, pol_state_data,
             pol_action_ready, grant_id, stat_timeouts, stat_grants} !== '0)
            begin errors++; $display("FAIL reset_outputs: some output nonzero (rsp_valid %b psv %b par %b)", rsp_valid, pol_state_valid, pol_action_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (req_ready !== '0 || pol_action_ready !== 1'b0 || stat_grants !== 16'd0)
            begin errors++; $display("FAIL post_reset_idle: req_ready %b par %b grants %0d expected 0 0 0", req_ready, pol_action_ready, stat_grants); end
    endtask

    task automatic test_round_robin();
        int g, exp_g;
        for (int t = 0; t < 5; t++) begin
            run_txn(4'b1111, 3, 0, g);
`ifdef AIE_ARB_PRIORITY_EN
            exp_g = 0;
`else
            exp_g = t % NUM_REQ;
`endif
            checks++;
            if (g !== exp_g) begin errors++; $display("FAIL rr_order: txn %0d grant %0d expected %0d", t, g, exp_g); end
        end
        checks++;
        if (stat_grants !== 16'd5) begin errors++; $display("FAIL rr_stat_grants: got %0d expected 5", stat_grants); end
    endtask

    task automatic test_single();
        int g;
        run_txn(4'b0100, 0, 0, g);
        checks++;
        if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_id: got %0d expected 2", grant_id); end
    endtask

    task automatic test_timeout();
        int g;
        run_txn(4'b0010, -1, 2, g);
        checks++;
        if (stat_timeouts !== 16'd1) begin errors++; $display("FAIL timeout_count: got %0d expected 1", stat_timeouts); end
    endtask

    task automatic test_late_drain();
        int g;
        repeat (10) begin
            checks++;
            if (pol_action_ready !== 1'b1 || pol_state_valid !== 1'b0)
                begin errors++; $display("FAIL drain_ready: par %b psv %b expected 1 0", pol_action_ready, pol_state_valid); end
            tick();
        end
        pol_action_valid = 1'b1;
        pol_action_data  = {2{32'hDEAD_BEEF}};
        tick();
        pol_action_valid = 1'b0;
        pol_action_data  = '0;
        m_drain = 1'b0;
        checks++;
        if (pol_action_ready !== 1'b0 || rsp_valid !== '0)
            begin errors++; $display("FAIL drain_clear: par %b rsp_valid %b expected 0 0", pol_action_ready, rsp_valid); end
        run_txn(4'b0010, 2, 0, g);
    endtask

    task automatic test_timeout_boundary();
        int g;
        run_txn(4'b1000, TIMEOUT_CYCLES - 1, 0, g);
        checks++;
        if (stat_timeouts !== 16'd1) begin errors++; $display("FAIL boundary_count: got %0d expected 1", stat_timeouts); end
    endtask

    task automatic test_rsp_hold();
        int g;
        run_txn(4'b0101, 1, 50, g);
    endtask

    task automatic test_random();
        int g;
        for (int t = 0; t < 20; t++) begin
            run_txn(NUM_REQ'($urandom_range(1, 15)), $urandom_range(0, 5), $urandom_range(0, 3), g);
        end
    endtask

    task automatic test_async_reset();
        int g, n;
        load_states();
        req_valid = 4'b1111;
        #1;
        n = 0;
        while (req_ready === '0 && n < 20) begin tick(); n++; end
        tick();
        pol_state_ready = 1'b1;
        tick();
        pol_state_ready = 1'b0;
        repeat (3) tick();
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_action_data, rsp_timeout, pol_state_valid, pol_state_data,
             pol_action_ready, grant_id, stat_timeouts, stat_grants} !== '0)
            begin errors++; $display("FAIL async_reset: psv %b par %b grant_id %0d grants %0d expected all 0", pol_state_valid, pol_action_ready, grant_id, stat_grants); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();
        run_txn(4'b1111, 1, 0, g);
        checks++;
        if (g !== 0 || stat_grants !== 16'd1)
            begin errors++; $display("FAIL reset_first_grant: grant %0d grants %0d expected 0 1", g, stat_grants); end
    endtask

`ifdef AIE_ARB_PRIORITY_EN
    task automatic test_priority();
        int g;
        for (int t = 0; t < 2; t++) begin
            run_txn(4'b1001, 0, 0, g);
            checks++;
            if (g !== 0) begin errors++; $display("FAIL priority: txn %0d grant %0d expected 0", t, g); end
        end
        run_txn(4'b1110, 0, 0, g);
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_late_drain();
        test_timeout_boundary();
        test_rsp_hold();
        test_random();
        test_async_reset();
`ifdef AIE_ARB_PRIORITY_EN
        test_priority();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
